gcd_sched: RTL



---
 rtl/gcd_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/gcd_sched.sv
// gcd_sched: shared GCD engine with a round-robin request front end.
//
// Up to NREQ requesters offer operand pairs over valid/ready. One requester
// is granted at a time, its pair is loaded into the A/B registers, and the
// subtract-and-compare loop runs until the operands are equal or one is zero.
// The result is returned with the owning requester index over valid/ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[NREQ]       per-requester operand pair valid
//   req_a/req_b           packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready[NREQ]       one-hot accept, only ever high in IDLE
//   res_valid/res_ready   result handshake
//   res_data, res_id      GCD result and index of the requester that owns it
//   busy                  high while a job is computing or waiting to return
//   res_iter              subtraction count (only with GCD_ITER_CNT_EN)
//
// Optional feature macro: GCD_ITER_CNT_EN adds the saturating iteration
// counter and the res_iter port.

module gcd_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [WIDTH-1:0]      res_iter
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   lastGrant_q, lastGrant_d;
`ifdef GCD_ITER_CNT_EN
  logic [WIDTH-1:0] iter_q, iter_d;
  logic [WIDTH-1:0] iterInc;
`endif

  logic             gntFound;
  logic [IDW-1:0]   gntIdx;
  logic [WIDTH-1:0] gntA;
  logic [WIDTH-1:0] gntB;
  int               cand;
  logic [IDW-1:0]   candIdx;

  // Round-robin search: scan NREQ slots starting just past the last grant
  // and take the first valid requester. Independent of state; only used in IDLE.
  always_comb begin
    gntFound = 1'b0;
    gntIdx   = '0;
    gntA     = '0;
    gntB     = '0;
    cand     = 0;
    candIdx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand    = (int'(lastGrant_q) + 1 + k) % NREQ;
      candIdx = IDW'(cand);
      if (!gntFound && req_valid[candIdx]) begin
        gntFound = 1'b1;
        gntIdx   = candIdx;
        gntA     = req_a[cand*WIDTH +: WIDTH];
        gntB     = req_b[cand*WIDTH +: WIDTH];
      end
    end
  end

`ifdef GCD_ITER_CNT_EN
  // Counter holds at all-ones instead of wrapping.
  assign iterInc = (iter_q == '1) ? iter_q : iter_q + WIDTH'(1);
`endif

  // Next-state, datapath and handshake logic. Only the larger operand is
  // reduced, so the unsigned subtraction never underflows.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    id_d        = id_q;
    lastGrant_d = lastGrant_q;
`ifdef GCD_ITER_CNT_EN
    iter_d      = iter_q;
`endif
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (gntFound) begin
          req_ready[gntIdx] = 1'b1;
          a_d               = gntA;
          b_d               = gntB;
          id_d              = gntIdx;
          lastGrant_d       = gntIdx;
`ifdef GCD_ITER_CNT_EN
          iter_d            = '0;
`endif
          state_d           = CALC;
        end
      end
      CALC: begin
        if ((a_q == b_q) || (a_q == '0) || (b_q == '0)) begin
          res_d   = (a_q == '0) ? b_q : a_q;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
`ifdef GCD_ITER_CNT_EN
          iter_d = iterInc;
`endif
        end else begin
          b_d = b_q - a_q;
`ifdef GCD_ITER_CNT_EN
          iter_d = iterInc;
`endif
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. last grant resets to NREQ-1 so that
  // requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      id_q        <= '0;
      lastGrant_q <= IDW'(NREQ - 1);
`ifdef GCD_ITER_CNT_EN
      iter_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      id_q        <= id_d;
      lastGrant_q <= lastGrant_d;
`ifdef GCD_ITER_CNT_EN
      iter_q      <= iter_d;
`endif
    end
  end

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_data  = res_q;
  assign res_id    = id_q;
`ifdef GCD_ITER_CNT_EN
  assign res_iter  = iter_q;
`endif

endmodule
